// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the ID/EX stage and the execute-stage ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;

  // Upstream side: issues requests, observes results and stall.
  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, valid_o, data_o, zero_o, busy_o
  );

  // ALU side.
  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, valid_o, data_o, zero_o, busy_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or, iterative shift-add multiply.
module alu_multicycle #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_multicycle_if.slave bus
);

  localparam int K  = WIDTH / MUL_STEP;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_ADD2 = 3'b101
  } op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state_q, state_d;
  logic             ready;
  logic             accept;
  logic             last_iter;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] step_sum;
  logic [WIDTH-1:0] partial_nxt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             valid_q;

  assign accept    = bus.valid_i & ready;
  assign last_iter = (cnt_q == CW'(K - 1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a mul leaves IDLE, the K-th iteration returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && bus.ALUCtrl_i == OP_MUL) state_d = MUL;
      MUL:  if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept requests only while idle.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
      MUL:     ready = 1'b0;
      default: ready = 1'b0;
    endcase
  end

  // Single-cycle result; illegal codes yield zero.
  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl_i)
      OP_ADD, OP_ADD2: alu_res = bus.data1_i + bus.data2_i;
      OP_SUB:          alu_res = bus.data1_i - bus.data2_i;
      OP_AND:          alu_res = bus.data1_i & bus.data2_i;
      OP_OR:           alu_res = bus.data1_i | bus.data2_i;
      default:         alu_res = '0;
    endcase
  end

  // One iteration's contribution: the multiplicand (pre-shifted by the
  // iterations already done) gated by each of the next MUL_STEP multiplier bits.
  always_comb begin
    step_sum = '0;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) step_sum = step_sum + (mcand_q << j);
    end
    partial_nxt = partial_q + step_sum;
  end

  // Datapath: operand capture, iteration and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        if (bus.ALUCtrl_i == OP_MUL) begin
          mcand_q   <= bus.data1_i;
          mplier_q  <= bus.data2_i;
          partial_q <= '0;
          cnt_q     <= '0;
        end else begin
          data_q  <= alu_res;
          zero_q  <= (alu_res == '0);
          valid_q <= 1'b1;
        end
      end else if (state_q == MUL) begin
        partial_q <= partial_nxt;
        mcand_q   <= mcand_q << MUL_STEP;
        mplier_q  <= mplier_q >> MUL_STEP;
        cnt_q     <= cnt_q + CW'(1);
        if (last_iter) begin
          data_q  <= partial_nxt;
          zero_q  <= (partial_nxt == '0);
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = ~ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against a behavioural reference.
module tb_alu_multicycle;

  localparam int W        = 32;
  localparam int MUL_STEP = 1;
  localparam int K        = W / MUL_STEP;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] last_data;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W), .MUL_STEP(MUL_STEP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0, 3'd5: r = a + b;
      3'd1:       r = a - b;
      3'd2:       r = a * b;
      3'd3:       r = a & b;
      3'd4:       r = a | b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble inputs after acceptance, wait for the result.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit hold_ok;
    logic [W-1:0] exp;
    exp = ref_alu(op, a, b);
    check("ready_before", bus.ready_o, 1);
    bus.valid_i = 1'b1; bus.ALUCtrl_i = op; bus.data1_i = a; bus.data2_i = b;
    tick();
    bus.valid_i = 1'b0;
    bus.ALUCtrl_i = 3'($urandom); bus.data1_i = $urandom; bus.data2_i = $urandom;
    n = 1;
    hold_ok = 1'b1;
    while (bus.valid_o !== 1'b1 && n < K + 5) begin
      if (!(bus.busy_o === 1'b1 && bus.ready_o === 1'b0 && bus.data_o === last_data)) hold_ok = 1'b0;
      tick();
      n++;
    end
    check($sformatf("latency op%0d", op), n, (op == 3'b010) ? K + 1 : 1);
    check("busy_hold", hold_ok, 1);
    check($sformatf("data op%0d", op), bus.data_o, exp);
    check("zero", bus.zero_o, (exp == '0));
    check("ready_after", bus.ready_o, 1);
    check("busy_after", bus.busy_o, 0);
    last_data = exp;
    tick();
    check("pulse_end", bus.valid_o, 0);
  endtask

  // Back-to-back single-cycle op: leaves valid_i raised for the caller.
  task automatic step_nonmul(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    exp = ref_alu(op, a, b);
    bus.valid_i = 1'b1; bus.ALUCtrl_i = op; bus.data1_i = a; bus.data2_i = b;
    tick();
    check($sformatf("b2b valid op%0d", op), bus.valid_o, 1);
    check($sformatf("b2b data op%0d", op), bus.data_o, exp);
    check($sformatf("b2b zero op%0d", op), bus.zero_o, (exp == '0));
    last_data = exp;
  endtask

  initial begin
    int n;
    bit ok;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_cmp = 0;
    n_err = 0;
    last_data = '0;
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.ALUCtrl_i = '0; bus.data1_i = '0; bus.data2_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", bus.valid_o, 0);
    check("rst data", bus.data_o, 0);
    check("rst zero", bus.zero_o, 0);
    rst = 1'b1;
    tick();
    check("rel ready", bus.ready_o, 1);
    check("rel busy", bus.busy_o, 0);

    // Add
    run_op(3'b000, 32'd5, 32'd7);

    // Sub pair back-to-back
    step_nonmul(3'b001, 32'd7, 32'd7);
    step_nonmul(3'b001, 32'd0, 32'd1);
    bus.valid_i = 1'b0;
    tick();
    check("sub pulse_end", bus.valid_o, 0);

    // Mul wrap
    run_op(3'b010, 32'hFFFF_FFFF, 32'd3);

    // Stall: add held while mul in flight
    bus.valid_i = 1'b1; bus.ALUCtrl_i = 3'b010; bus.data1_i = 32'd12345; bus.data2_i = 32'd678;
    tick();
    bus.ALUCtrl_i = 3'b000; bus.data1_i = 32'd1; bus.data2_i = 32'd1;
    n = 1;
    ok = 1'b1;
    while (bus.valid_o !== 1'b1 && n < K + 5) begin
      if (!(bus.ready_o === 1'b0 && bus.data_o === last_data)) ok = 1'b0;
      tick();
      n++;
    end
    check("stall latency", n, K + 1);
    check("stall hold", ok, 1);
    check("stall mul data", bus.data_o, 32'd8369910);
    tick();
    bus.valid_i = 1'b0;
    check("stall add valid", bus.valid_o, 1);
    check("stall add data", bus.data_o, 32'd2);
    check("stall add zero", bus.zero_o, 0);
    last_data = 32'd2;
    tick();
    check("stall pulse_end", bus.valid_o, 0);

    // Reset mid-mul
    bus.valid_i = 1'b1; bus.ALUCtrl_i = 3'b010; bus.data1_i = 32'd1234567; bus.data2_i = 32'd89;
    tick();
    bus.valid_i = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort valid", bus.valid_o, 0);
    check("abort data", bus.data_o, 0);
    check("abort zero", bus.zero_o, 0);
    check("abort ready", bus.ready_o, 1);
    ok = 1'b1;
    repeat (K + 2) begin
      tick();
      if (bus.valid_o !== 1'b0) ok = 1'b0;
    end
    check("abort no pulse", ok, 1);
    last_data = '0;

    // Logic / illegal back-to-back
    step_nonmul(3'b011, 32'h0000_F0F0, 32'h0000_FF00);
    step_nonmul(3'b100, 32'h0000_F0F0, 32'h0000_FF00);
    step_nonmul(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.valid_i = 1'b0;
    tick();
    check("logic pulse_end", bus.valid_o, 0);

    // Randomized ops against the reference
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = ~a;
        2:       b = W'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), a, b);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
